// File: rtl/sha_nonce_search.sv
// rtl/sha_nonce_search.sv - nonce search controller driving a shared-memory SHA-256 hasher
module sha_nonce_search #(
    parameter int NONCE_IDX  = 19,
    parameter int HASH_WORDS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [15:0]  header_addr,
    input  logic [15:0]  hash_addr,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_count,
    input  logic [255:0] target,
    output logic         hasher_start,
    input  logic         hasher_done,
    output logic         mem_owner,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_write_data,
    input  logic [31:0]  mem_read_data,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [31:0]  nonces_tried
);

    localparam logic [15:0] NONCE_OFF = 16'(NONCE_IDX);
    localparam logic [2:0]  K_LAST    = 3'(HASH_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE,
        WR_NONCE,
        START_H,
        WAIT_BUSY,
        WAIT_DONE,
        RD_ADDR,
        RD_DATA,
        CHECK,
        FINISH
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [15:0]    header_addr_q;
    logic [15:0]    hash_addr_q;
    logic [255:0]   target_q;
    logic [31:0]    nonce_q;
    logic [31:0]    remaining_q;
    logic [2:0]     k_q;
    logic [31:0]    hash_q [HASH_WORDS];
    logic [255:0]   hash_vec;
    logic           hit;

    // h0 lands in the most significant word so the compare is a plain unsigned 256-bit one
    always_comb begin
        hash_vec = '0;
        for (int i = 0; i < HASH_WORDS; i++) begin
            hash_vec[255 - 32 * i -: 32] = hash_q[i];
        end
    end

    assign hit = (hash_vec < target_q);

    // state register; reset aborts any search and releases memory and hasher
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decode and per-state memory/hasher strobes
    always_comb begin
        state_d        = state_q;
        hasher_start   = 1'b0;
        mem_owner      = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        busy           = 1'b1;
        done           = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (nonce_count == 32'd0) ? FINISH : WR_NONCE;
                end
            end
            WR_NONCE: begin
                mem_owner      = 1'b1;
                mem_we         = 1'b1;
                mem_addr       = header_addr_q + NONCE_OFF;
                mem_write_data = nonce_q;
                state_d        = START_H;
            end
            START_H: begin
                hasher_start = 1'b1;
                state_d      = WAIT_BUSY;
            end
            // the hasher's done idles high, so first see it drop before waiting for it to rise
            WAIT_BUSY: begin
                if (!hasher_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (hasher_done) begin
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                mem_owner = 1'b1;
                mem_addr  = hash_addr_q + 16'(k_q);
                state_d   = RD_DATA;
            end
            // keep owning the memory while the registered read data returns
            RD_DATA: begin
                mem_owner = 1'b1;
                mem_addr  = hash_addr_q + 16'(k_q);
                state_d   = (k_q == K_LAST) ? CHECK : RD_ADDR;
            end
            CHECK: begin
                if (hit || remaining_q == 32'd1) begin
                    state_d = FINISH;
                end else begin
                    state_d = WR_NONCE;
                end
            end
            FINISH: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // search bookkeeping: latched job, current nonce, budget and results
    always_ff @(posedge clk) begin
        if (rst) begin
            header_addr_q <= '0;
            hash_addr_q   <= '0;
            target_q      <= '0;
            nonce_q       <= '0;
            remaining_q   <= '0;
            k_q           <= '0;
            found         <= 1'b0;
            found_nonce   <= '0;
            nonces_tried  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        header_addr_q <= header_addr;
                        hash_addr_q   <= hash_addr;
                        target_q      <= target;
                        nonce_q       <= nonce_start;
                        remaining_q   <= nonce_count;
                        found         <= 1'b0;
                        found_nonce   <= '0;
                        nonces_tried  <= '0;
                    end
                end
                WAIT_DONE: begin
                    k_q <= '0;
                end
                RD_DATA: begin
                    k_q <= k_q + 3'd1;
                end
                CHECK: begin
                    nonces_tried <= nonces_tried + 32'd1;
                    if (hit) begin
                        found       <= 1'b1;
                        found_nonce <= nonce_q;
                    end else begin
                        remaining_q <= remaining_q - 32'd1;
                        nonce_q     <= nonce_q + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // hash word capture; contents are only meaningful once all eight words are in
    always_ff @(posedge clk) begin
        if (state_q == RD_DATA) begin
            hash_q[k_q] <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_sha_nonce_search.sv
// tb/tb_sha_nonce_search.sv - randomized self-checking bench for sha_nonce_search
module tb_sha_nonce_search;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  header_addr = '0;
    logic [15:0]  hash_addr = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_count = '0;
    logic [255:0] target = '0;
    logic         hasher_start;
    logic         hasher_done = 1'b1;
    logic         mem_owner;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data = '0;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  found_nonce;
    logic [31:0]  nonces_tried;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:65535];
    int          h_mode = 0;
    int          h_lat = 30;
    int          h_cnt = 0;
    logic [15:0] h_hdr_base = '0;
    logic [15:0] h_hash_base = '0;

    logic [31:0] wr_q[$];
    logic [15:0] exp_wr_addr = '0;
    int          bad_wr = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;

    sha_nonce_search dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .header_addr    (header_addr),
        .hash_addr      (hash_addr),
        .nonce_start    (nonce_start),
        .nonce_count    (nonce_count),
        .target         (target),
        .hasher_start   (hasher_start),
        .hasher_done    (hasher_done),
        .mem_owner      (mem_owner),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .done           (done),
        .found          (found),
        .found_nonce    (found_nonce),
        .nonces_tried   (nonces_tried)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hash_word(input int mode, input logic [31:0] n, input int i);
        logic [31:0] x;
        if (mode == 0) begin
            return (i == 0) ? (32'h10 - n) : 32'h0;
        end
        x = n * 32'h9E3779B1 + 32'(i) * 32'h85EBCA6B;
        x = x ^ (x >> 15);
        x = x * 32'h2C1B3C6D;
        x = x ^ (x >> 12);
        return x;
    endfunction

    function automatic logic [255:0] full_hash(input int mode, input logic [31:0] n);
        logic [255:0] h;
        h = '0;
        for (int i = 0; i < 8; i++) begin
            h = {h[223:0], hash_word(mode, n, i)};
        end
        return h;
    endfunction

    // memory with one-cycle read latency plus a stub hasher sharing it
    always @(posedge clk) begin
        if (mem_owner && mem_we) begin
            mem[mem_addr] <= mem_write_data;
        end
        mem_read_data <= mem[mem_addr];
        if (hasher_start) begin
            hasher_done <= 1'b0;
            h_cnt       <= h_lat;
        end else if (!hasher_done) begin
            if (h_cnt == 0) begin
                for (int i = 0; i < 8; i++) begin
                    mem[16'(h_hash_base + 16'(i))] <= hash_word(h_mode, mem[16'(h_hdr_base + 16'd19)], i);
                end
                hasher_done <= 1'b1;
            end else begin
                h_cnt <= h_cnt - 1;
            end
        end
    end

    // bus monitor
    always @(negedge clk) begin
        if (mem_we) begin
            wr_q.push_back(mem_write_data);
            if (mem_addr != exp_wr_addr || !mem_owner || hasher_start) begin
                bad_wr++;
            end
        end
        if (hasher_start) hs_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        bad_wr   = 0;
        hs_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic run_search(input string tag, input logic [15:0] hdr, input logic [15:0] hsh,
                              input logic [31:0] ns, input logic [31:0] nc, input logic [255:0] tgt,
                              input int mode, input int lat);
        logic [31:0] exp_writes[$];
        logic        exp_found;
        logic [31:0] exp_nonce;
        int          exp_tried;
        logic [31:0] n;
        int          cyc;
        int          wr_bad;

        exp_found = 1'b0;
        exp_nonce = '0;
        exp_tried = 0;
        n = ns;
        for (longint j = 0; j < longint'(nc); j++) begin
            exp_writes.push_back(n);
            exp_tried++;
            if (full_hash(mode, n) < tgt) begin
                exp_found = 1'b1;
                exp_nonce = n;
                break;
            end
            n = n + 32'd1;
        end

        h_mode      = mode;
        h_lat       = lat;
        h_hdr_base  = hdr;
        h_hash_base = hsh;
        exp_wr_addr = hdr + 16'd19;
        clear_mon();
        @(posedge clk); #1;
        header_addr = hdr;
        hash_addr   = hsh;
        nonce_start = ns;
        nonce_count = nc;
        target      = tgt;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_found"}, 64'(found), 64'(exp_found));
        check({tag, "_found_nonce"}, 64'(found_nonce), 64'(exp_nonce));
        check({tag, "_tried"}, 64'(nonces_tried), 64'(exp_tried));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_hasher_starts"}, 64'(hs_cnt), 64'(exp_tried));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_writes.size()));
        wr_bad = bad_wr;
        for (int i = 0; i < wr_q.size() && i < exp_writes.size(); i++) begin
            if (wr_q[i] !== exp_writes[i]) wr_bad++;
        end
        check({tag, "_write_stream"}, 64'(wr_bad), 64'd0);
    endtask

    initial begin
        logic [255:0] tgt;
        int           cyc;

        for (int i = 0; i < 65536; i++) mem[i] = 32'(i) ^ 32'hA5A5_0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {10'd0, mem_addr, mem_write_data, hasher_start, mem_owner, mem_we, busy, done, found}, 64'd0);
        check("rst_results", {found_nonce, nonces_tried}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // empty budget: straight to done, no bus or hasher activity
        clear_mon();
        @(posedge clk); #1;
        nonce_count = 32'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_done_latency", 64'(done), 64'd1);
        repeat (3) @(negedge clk);
        check("zero_no_activity", {32'(hs_cnt), 32'(wr_q.size())}, 64'd0);
        run_search("zero", 16'h0000, 16'h0100, 32'd5, 32'd0, '1, 0, 30);

        run_search("single", 16'h0200, 16'h0300, 32'd0, 32'd1, '1, 1, 30);
        run_search("stub_hit", 16'h0000, 16'h0100, 32'd0, 32'd10, {32'h0000_000E, 224'h0}, 0, 30);
        run_search("wrap", 16'hFFF0, 16'h0100, 32'hFFFF_FFFE, 32'd3, 256'h0, 0, 30);

        // reset while waiting on the hasher
        clear_mon();
        h_mode = 0; h_lat = 30; h_hdr_base = 16'h0400; h_hash_base = 16'h0500;
        exp_wr_addr = 16'h0400 + 16'd19;
        @(posedge clk); #1;
        header_addr = 16'h0400; hash_addr = 16'h0500;
        nonce_start = 32'd7; nonce_count = 32'd5; target = 256'h0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (hs_cnt < 2 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        check("rstmid_reached", 64'(hs_cnt), 64'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rstmid_before", {31'd0, busy, nonces_tried}, {31'd0, 1'b1, 32'd1});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_ctrl", {10'd0, mem_addr, mem_write_data, hasher_start, mem_owner, mem_we, busy, done, found}, 64'd0);
        check("rstmid_results", {found_nonce, nonces_tried}, 64'd0);
        cyc = 0;
        while (!hasher_done && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        check("rstmid_hasher_idle", 64'(hasher_done), 64'd1);
        run_search("after_rst", 16'h0400, 16'h0500, 32'd0, 32'd10, {32'h0000_000E, 224'h0}, 0, 12);

        // start held high across a whole search
        clear_mon();
        h_mode = 0; h_lat = 5; h_hdr_base = 16'h0600; h_hash_base = 16'h0700;
        exp_wr_addr = 16'h0600 + 16'd19;
        @(posedge clk); #1;
        header_addr = 16'h0600; hash_addr = 16'h0700;
        nonce_start = 32'd100; nonce_count = 32'd2; target = 256'h0;
        start = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("held_first_done", {31'd0, done, nonces_tried}, {31'd0, 1'b1, 32'd2});
        check("held_first_starts", 64'(hs_cnt), 64'd2);
        @(negedge clk);
        check("held_idle_gap", 64'(busy), 64'd0);
        @(negedge clk);
        check("held_restart", 64'(busy), 64'd1);
        start = 1'b0;
        cyc = 0;
        while (done_cnt < 2 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        check("held_second_done", 64'(done_cnt), 64'd2);
        check("held_total_starts", 64'(hs_cnt), 64'd4);

        // randomized jobs against the reference search
        for (int t = 0; t < 8; t++) begin
            logic [15:0] hdr;
            hdr = 16'($urandom);
            tgt[255:224] = $urandom_range(0, 32'h3000_0000);
            for (int w = 0; w < 7; w++) tgt[w * 32 +: 32] = $urandom;
            run_search($sformatf("rand%0d", t), hdr, 16'(hdr + 16'h0100), $urandom,
                       32'($urandom_range(1, 12)), tgt, 1, $urandom_range(1, 40));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
